// File: rtl/forwarding_control_pkg.sv
// Shared types for the operand-forwarding controller: scoreboard entry layout,
// stall FSM states and register-file constants.
package forwarding_control_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } sb_entry_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    STALLED = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/forwarding_control_fwd_match.sv
// Combinational comparator: does a scoreboard entry produce the source register
// an instruction reads? Register zero never matches.
module fwd_match
  import forwarding_control_pkg::*;
(
  input  sb_entry_t             i_entry,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_use,
  input  logic                  i_load_only,
  output logic                  o_match
);

  // i_load_only restricts the match to load producers.
  assign o_match = i_use
                 & i_entry.valid
                 & i_entry.regwrite
                 & (i_entry.rd != REG_ZERO)
                 & (i_entry.rd == i_rs)
                 & (i_entry.is_load | ~i_load_only);

endmodule

// File: rtl/forwarding_control.sv
// Operand-forwarding and load-use hazard controller: tracks EX/MEM destinations,
// registers forwarding selects for the instruction entering EX, stalls on load-use.
module forwarding_control
  import forwarding_control_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   ID_Valid,
  input  logic [REG_ADDR_W-1:0]  ID_RsA,
  input  logic [REG_ADDR_W-1:0]  ID_RsB,
  input  logic                   ID_UseA,
  input  logic                   ID_UseB,
  input  logic [REG_ADDR_W-1:0]  ID_Rd,
  input  logic                   ID_RegWrite,
  input  logic                   ID_IsLoad,
  input  logic                   Hold,
  input  logic                   Flush,
  output logic                   One_A,
  output logic                   One_B,
  output logic                   Two_A,
  output logic                   Two_B,
  output logic                   Stall,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  sb_entry_t              r_ex;
  sb_entry_t              r_mem;
  fwd_state_e             r_state;
  logic                   r_one_a;
  logic                   r_one_b;
  logic                   r_two_a;
  logic                   r_two_b;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic       w_one_a;
  logic       w_one_b;
  logic       w_mem_a;
  logic       w_mem_b;
  logic       w_stall;
  logic       w_bubble;
  sb_entry_t  w_id_entry;
  fwd_state_e w_state_nxt;

  fwd_match u_one_a (
    .i_entry(r_ex), .i_rs(ID_RsA), .i_use(ID_UseA), .i_load_only(1'b0), .o_match(w_one_a)
  );
  fwd_match u_one_b (
    .i_entry(r_ex), .i_rs(ID_RsB), .i_use(ID_UseB), .i_load_only(1'b0), .o_match(w_one_b)
  );
  fwd_match u_two_a (
    .i_entry(r_mem), .i_rs(ID_RsA), .i_use(ID_UseA), .i_load_only(1'b0), .o_match(w_mem_a)
  );
  fwd_match u_two_b (
    .i_entry(r_mem), .i_rs(ID_RsB), .i_use(ID_UseB), .i_load_only(1'b0), .o_match(w_mem_b)
  );

  // In STALLED the load already sits in MEM, so the held instruction must not re-stall.
  assign w_stall  = Reset_n & (r_state == RUN) & ID_Valid & ~Flush
                  & r_ex.is_load & (w_one_a | w_one_b);
  assign w_bubble = w_stall | Flush | ~ID_Valid;

  always_comb begin
    w_id_entry          = '0;
    w_id_entry.valid    = ~w_bubble;
    w_id_entry.rd       = ID_Rd;
    w_id_entry.regwrite = ID_RegWrite;
    w_id_entry.is_load  = ID_IsLoad;
    w_state_nxt         = w_stall ? STALLED : RUN;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_state     <= RUN;
      r_one_a     <= 1'b0;
      r_one_b     <= 1'b0;
      r_two_a     <= 1'b0;
      r_two_b     <= 1'b0;
      r_stall_cnt <= '0;
    end else if (!Hold) begin
      r_mem   <= r_ex;
      r_ex    <= w_id_entry;
      r_state <= w_state_nxt;
      r_one_a <= ~w_bubble & w_one_a;
      r_one_b <= ~w_bubble & w_one_b;
      r_two_a <= ~w_bubble & w_mem_a & ~w_one_a;
      r_two_b <= ~w_bubble & w_mem_b & ~w_one_b;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign One_A      = r_one_a;
  assign One_B      = r_one_b;
  assign Two_A      = r_two_a;
  assign Two_B      = r_two_b;
  assign Stall      = w_stall;
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_forwarding_control.sv
// Self-checking bench for forwarding_control: directed hazard scenarios followed by
// randomized traffic, all compared against an instruction-level reference model.
module tb_forwarding_control;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Reset_n;
  logic             ID_Valid;
  logic [3:0]       ID_RsA;
  logic [3:0]       ID_RsB;
  logic             ID_UseA;
  logic             ID_UseB;
  logic [3:0]       ID_Rd;
  logic             ID_RegWrite;
  logic             ID_IsLoad;
  logic             Hold;
  logic             Flush;
  logic             One_A;
  logic             One_B;
  logic             Two_A;
  logic             Two_B;
  logic             Stall;
  logic [CNT_W-1:0] StallCount;

  forwarding_control #(.STALL_CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ID_Valid(ID_Valid),
    .ID_RsA(ID_RsA), .ID_RsB(ID_RsB), .ID_UseA(ID_UseA), .ID_UseB(ID_UseB),
    .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_IsLoad(ID_IsLoad),
    .Hold(Hold), .Flush(Flush),
    .One_A(One_A), .One_B(One_B), .Two_A(Two_A), .Two_B(Two_B),
    .Stall(Stall), .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: the instruction occupying each later stage.
  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  instr_t      m_ex       = '0;
  instr_t      m_mem      = '0;
  bit          m_stalled  = 1'b0;
  int unsigned m_cnt      = 0;
  bit          e_one_a    = 1'b0;
  bit          e_one_b    = 1'b0;
  bit          e_two_a    = 1'b0;
  bit          e_two_b    = 1'b0;
  logic        obs_stall;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit produces(instr_t s, logic [3:0] r);
    return s.v && s.wr && (r != 4'd0) && (s.rd == r);
  endfunction

  function automatic bit model_stall();
    return Reset_n && ID_Valid && !Flush && !m_stalled && m_ex.ld &&
           ((ID_UseA && produces(m_ex, ID_RsA)) || (ID_UseB && produces(m_ex, ID_RsB)));
  endfunction

  task automatic model_edge();
    bit st;
    bit bub;
    if (!Reset_n) begin
      m_ex = '0; m_mem = '0; m_stalled = 1'b0; m_cnt = 0;
      e_one_a = 1'b0; e_one_b = 1'b0; e_two_a = 1'b0; e_two_b = 1'b0;
    end else if (!Hold) begin
      st  = model_stall();
      bub = st || Flush || !ID_Valid;
      e_one_a = !bub && ID_UseA && produces(m_ex, ID_RsA);
      e_one_b = !bub && ID_UseB && produces(m_ex, ID_RsB);
      e_two_a = !bub && ID_UseA && produces(m_mem, ID_RsA) && !e_one_a;
      e_two_b = !bub && ID_UseB && produces(m_mem, ID_RsB) && !e_one_b;
      m_mem = m_ex;
      m_ex  = '{v: !bub, rd: ID_Rd, wr: ID_RegWrite, ld: ID_IsLoad};
      m_stalled = st;
      if (st && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic v, input logic [3:0] ra, input logic [3:0] rb,
                     input logic ua, input logic ub, input logic [3:0] rd, input logic rw,
                     input logic ld, input logic h, input logic f);
    Reset_n = rn; ID_Valid = v; ID_RsA = ra; ID_RsB = rb; ID_UseA = ua; ID_UseB = ub;
    ID_Rd = rd; ID_RegWrite = rw; ID_IsLoad = ld; Hold = h; Flush = f;
    #1;
    obs_stall = Stall;
    check("stall_pre", 32'(Stall), 32'(model_stall()));
    @(posedge Clk);
    model_edge();
    #1;
    check("one_a", 32'(One_A), 32'(e_one_a));
    check("one_b", 32'(One_B), 32'(e_one_b));
    check("two_a", 32'(Two_A), 32'(e_two_a));
    check("two_b", 32'(Two_B), 32'(e_two_b));
    check("count", 32'(StallCount), m_cnt);
    check("stall_post", 32'(Stall), 32'(model_stall()));
    @(negedge Clk);
  endtask

  task automatic ins(input logic [3:0] ra, input logic [3:0] rb, input logic ua, input logic ub,
                     input logic [3:0] rd, input logic rw, input logic ld);
    cyc(1'b1, 1'b1, ra, rb, ua, ub, rd, rw, ld, 1'b0, 1'b0);
  endtask

  task automatic nop();
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_cyc(input logic rn);
    cyc(rn, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
        1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
  endtask

  initial begin
    // Reset with random inputs; stall stays low throughout.
    for (int i = 0; i < 2; i++) begin
      rand_cyc(1'b0);
      check("rst_stall", 32'(obs_stall), 32'd0);
    end
    check("rst_count", 32'(StallCount), 32'd0);
    nop();
    check("rst_sel", 32'({One_A, One_B, Two_A, Two_B}), 32'd0);

    // ADD r3 <- r1,r2 ; SUB r5 <- r3,r4
    ins(4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    ins(4'd3, 4'd4, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    check("sub_sel", 32'({One_A, Two_A, One_B, Two_B}), 32'b1000);
    check("sub_nostall", 32'(obs_stall), 32'd0);

    // ADD r3 ; NOP ; OR r6 <- r2,r3  -> MEM forwarding on B
    ins(4'd1, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    nop();
    ins(4'd2, 4'd3, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
    check("or_two_b", 32'({One_B, Two_B}), 32'b01);

    // ADD r3 ; ADD r3 ; OR r6 <- r2,r3  -> EX wins over MEM
    ins(4'd1, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    ins(4'd1, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    ins(4'd2, 4'd3, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
    check("or_prio", 32'({One_B, Two_B}), 32'b10);

    // LOAD r2 ; ADD r7 <- r2,r2 : one stall cycle then MEM forwarding on both
    ins(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
    ins(4'd2, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    check("lu_stall", 32'(obs_stall), 32'd1);
    check("lu_bubble", 32'({One_A, One_B, Two_A, Two_B}), 32'd0);
    check("lu_count", 32'(StallCount), 32'd1);
    ins(4'd2, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    check("lu_stall_once", 32'(obs_stall), 32'd0);
    check("lu_fwd", 32'({One_A, One_B, Two_A, Two_B}), 32'b0011);

    // Same hazard held by Hold for three cycles
    ins(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      check("hold_stall", 32'(obs_stall), 32'd1);
      check("hold_count", 32'(StallCount), 32'd1);
    end
    ins(4'd2, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    check("hold_count_inc", 32'(StallCount), 32'd2);
    ins(4'd2, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    check("hold_fwd", 32'({One_A, One_B, Two_A, Two_B}), 32'b0011);

    // Register zero never forwards or stalls
    ins(4'd1, 4'd1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    ins(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    check("r0_nostall", 32'(obs_stall), 32'd0);
    check("r0_sel", 32'({One_A, One_B, Two_A, Two_B}), 32'd0);

    // Flush beats the load-use stall
    ins(4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    check("flush_nostall", 32'(obs_stall), 32'd0);
    check("flush_count", 32'(StallCount), 32'd2);
    check("flush_bubble", 32'({One_A, One_B, Two_A, Two_B}), 32'd0);

    // Reset in the middle of a stall
    ins(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst_count", 32'(StallCount), 32'd0);
    ins(4'd2, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
    check("mid_rst_nostall", 32'(obs_stall), 32'd0);

    // Drive the counter into saturation
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      ins(4'd1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1);
      ins(4'd2, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
      ins(4'd2, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
    end
    check("sat_count", 32'(StallCount), CNT_MAX);

    // Randomized traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      rand_cyc(1'($urandom_range(0, 59) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
